rmii_frame_rx: RTL and testbench



---
 rtl/rmii_frame_rx.sv | 237 +++++++++++++++++++++++
 tb/tb_rmii_frame_rx.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rmii_frame_rx.sv
// rmii_frame_rx: RMII receive front end.
// Validates and strips the preamble/SFD from raw RMII dibits (LSB-first per
// byte), then replays each complete body byte as MSB-first dibits on
// axiov/axiod for the MAC-address firewall stage.
// Optional build macro RMII_FRAME_RX_STATS_EN adds saturating frame_cnt and
// err_cnt outputs; without it those ports and counters do not exist.
module rmii_frame_rx #(
  parameter int PRE_MIN = 31,
  parameter int CNT_W   = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        crsdv,
  input  logic [1:0]  rxd,
  output logic        axiov,
  output logic [1:0]  axiod,
  output logic        pre_err,
  output logic        align_err
`ifdef RMII_FRAME_RX_STATS_EN
  ,
  output logic [15:0] frame_cnt,
  output logic [15:0] err_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    DATA     = 2'd2,
    DROP     = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] PRE_MIN_C = CNT_W'(PRE_MIN);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       phase_q, phase_d;
  // Only bits [5:0] of a byte are ever stored: [7:6] arrive on the final
  // dibit and go straight to the output.
  logic [5:0]       cap_q, cap_d;
  logic [5:0]       hold_q, hold_d;
  logic [1:0]       emit_q, emit_d;
  logic             axiov_q, axiov_d;
  logic [1:0]       axiod_q, axiod_d;
  logic             pre_err_q, pre_err_d;
  logic             align_err_q, align_err_d;
  logic             arm;

  // State register; reset parks the FSM in DROP so a frame in flight is ignored
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DROP;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic for preamble tracking, body capture and frame discard
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (crsdv) begin
          if (rxd == 2'b01) begin
            state_d = PREAMBLE;
          end else if (rxd[1]) begin
            state_d = DROP;
          end
        end
      end
      PREAMBLE: begin
        if (!crsdv) begin
          state_d = IDLE;
        end else if (rxd == 2'b01) begin
          state_d = PREAMBLE;
        end else if ((rxd == 2'b11) && (cnt_q >= PRE_MIN_C)) begin
          state_d = DATA;
        end else begin
          state_d = DROP;
        end
      end
      DATA: begin
        if (!crsdv) begin
          state_d = IDLE;
        end
      end
      DROP: begin
        if (!crsdv) begin
          state_d = IDLE;
        end
      end
      default: state_d = DROP;
    endcase
  end

  // Per-state outputs: preamble count, byte capture, arming and error pulses
  always_comb begin
    cnt_d       = cnt_q;
    phase_d     = phase_q;
    cap_d       = cap_q;
    pre_err_d   = 1'b0;
    align_err_d = 1'b0;
    arm         = 1'b0;
    case (state_q)
      IDLE: begin
        if (crsdv && (rxd == 2'b01)) begin
          cnt_d = CNT_ONE;
        end
        if (crsdv && rxd[1]) begin
          pre_err_d = 1'b1;
        end
      end
      PREAMBLE: begin
        if (!crsdv) begin
          pre_err_d = 1'b1;
        end else if (rxd == 2'b01) begin
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else if ((rxd == 2'b11) && (cnt_q >= PRE_MIN_C)) begin
          phase_d = 2'd0;
        end else begin
          pre_err_d = 1'b1;
        end
      end
      DATA: begin
        if (crsdv) begin
          case (phase_q)
            2'd0:    cap_d[1:0] = rxd;
            2'd1:    cap_d[3:2] = rxd;
            2'd2:    cap_d[5:4] = rxd;
            default: arm = 1'b1;
          endcase
          phase_d = phase_q + 2'd1;
        end else begin
          phase_d = 2'd0;
          if (phase_q != 2'd0) begin
            align_err_d = 1'b1;
          end
        end
      end
      default: begin
      end
    endcase
  end

  // Output engine: replays the held byte MSB-first over four cycles, re-arming seamlessly
  always_comb begin
    hold_d  = hold_q;
    emit_d  = emit_q;
    axiov_d = axiov_q;
    axiod_d = axiod_q;
    if (arm) begin
      hold_d  = cap_q;
      emit_d  = 2'd0;
      axiov_d = 1'b1;
      axiod_d = rxd;
    end else if (axiov_q && (emit_q != 2'd3)) begin
      emit_d  = emit_q + 2'd1;
      axiov_d = 1'b1;
      case (emit_q)
        2'd0:    axiod_d = hold_q[5:4];
        2'd1:    axiod_d = hold_q[3:2];
        default: axiod_d = hold_q[1:0];
      endcase
    end else begin
      axiov_d = 1'b0;
    end
  end

  // Datapath and output registers; reset discards any byte waiting to be emitted
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      phase_q     <= 2'd0;
      cap_q       <= 6'd0;
      hold_q      <= 6'd0;
      emit_q      <= 2'd0;
      axiov_q     <= 1'b0;
      axiod_q     <= 2'd0;
      pre_err_q   <= 1'b0;
      align_err_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      phase_q     <= phase_d;
      cap_q       <= cap_d;
      hold_q      <= hold_d;
      emit_q      <= emit_d;
      axiov_q     <= axiov_d;
      axiod_q     <= axiod_d;
      pre_err_q   <= pre_err_d;
      align_err_q <= align_err_d;
    end
  end

  assign axiov     = axiov_q;
  assign axiod     = axiod_q;
  assign pre_err   = pre_err_q;
  assign align_err = align_err_q;

`ifdef RMII_FRAME_RX_STATS_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic        frame_done;

  assign frame_done = (state_q == DATA) && !crsdv && (phase_q == 2'd0);

  // Saturating counts of cleanly ended frames and of error pulses
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    if (frame_done && (frame_cnt_q != 16'hFFFF)) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
    if ((pre_err_d || align_err_d) && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  // Statistics registers
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= 16'd0;
      err_cnt_q   <= 16'd0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_rmii_frame_rx.sv
// tb_rmii_frame_rx: self-checking bench for rmii_frame_rx.
// A table of frame records drives the DUT; expected output dibits are pushed
// to a scoreboard queue as each complete body byte is driven and popped as
// the DUT emits valid dibits. Define RMII_FRAME_RX_STATS_EN to also check the
// statistics outputs.
module tb_rmii_frame_rx;

  localparam int PRE_MIN = 31;

  typedef struct {
    int          lead00;
    int          pre_len;
    logic [1:0]  sfd;
    int          nbytes;
    logic [63:0] body;
    int          extra;
    int          rst_byte;
    int          exp_valid;
    int          exp_pre;
    int          exp_align;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        crsdv;
  logic [1:0]  rxd;
  logic        axiov;
  logic [1:0]  axiod;
  logic        pre_err;
  logic        align_err;
`ifdef RMII_FRAME_RX_STATS_EN
  logic [15:0] frame_cnt;
  logic [15:0] err_cnt;
`endif

  int         n_checks = 0;
  int         n_pass   = 0;
  int         cyc      = 0;
  logic       prev_v   = 1'b0;
  logic [1:0] last_d   = 2'b00;
  logic       in_data  = 1'b0;
  logic [1:0] exp_q[$];
  int         n_valid, bursts, first_v, n_pre, n_align, align_tick, fall_tick, body_start;
  vec_t       vecs[11];
  vec_t       good_a, good_b;

  rmii_frame_rx #(
    .PRE_MIN(PRE_MIN),
    .CNT_W  (6)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .crsdv    (crsdv),
    .rxd      (rxd),
    .axiov    (axiov),
    .axiod    (axiod),
    .pre_err  (pre_err),
`ifdef RMII_FRAME_RX_STATS_EN
    .align_err(align_err),
    .frame_cnt(frame_cnt),
    .err_cnt  (err_cnt)
`else
    .align_err(align_err)
`endif
  );

  // Free-running clock, one RMII dibit per period
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic monitor();
    logic [1:0] e;
    if (axiov) begin
      n_valid++;
      if (!prev_v) begin
        bursts++;
        if (first_v < 0) first_v = cyc;
      end
      checkOutput("valid_has_expected_entry", int'(axiov), int'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checkOutput("axiod", int'(axiod), int'(e));
        last_d = e;
      end
    end else if (prev_v) begin
      checkOutput("axiod_hold", int'(axiod), int'(last_d));
    end
    if (pre_err) n_pre++;
    if (align_err) begin
      n_align++;
      align_tick = cyc;
    end
    prev_v = axiov;
  endtask

  // One cycle: drive inputs, sample outputs mid-cycle, advance past the edge
  task automatic tick(input logic v, input logic [1:0] d, input logic r);
    crsdv = v;
    rxd   = d;
    rst   = r;
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
    if (r) begin
      exp_q.delete();
      last_d  = 2'b00;
      in_data = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 2'b00, 1'b0);
  endtask

  task automatic clear_frame_stats();
    n_valid    = 0;
    bursts     = 0;
    first_v    = -1;
    n_pre      = 0;
    n_align    = 0;
    align_tick = -1;
    fall_tick  = -1;
    body_start = -1;
  endtask

  task automatic do_reset();
    tick(1'b0, 2'b00, 1'b1);
    tick(1'b0, 2'b00, 1'b1);
    crsdv = 1'b0;
    rxd   = 2'b00;
    rst   = 1'b0;
    @(negedge clk);
    checkOutput("reset_axiov", int'(axiov), 0);
    checkOutput("reset_axiod", int'(axiod), 0);
    checkOutput("reset_pre_err", int'(pre_err), 0);
    checkOutput("reset_align_err", int'(align_err), 0);
`ifdef RMII_FRAME_RX_STATS_EN
    checkOutput("reset_frame_cnt", int'(frame_cnt), 0);
    checkOutput("reset_err_cnt", int'(err_cnt), 0);
`endif
    prev_v = axiov;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Drive one frame; complete bytes of an accepted frame go to the scoreboard
  task automatic drive_frame(input vec_t v);
    logic [7:0] b;
    in_data = (v.pre_len >= PRE_MIN) && (v.sfd == 2'b11);
    for (int i = 0; i < v.lead00; i++) tick(1'b1, 2'b00, 1'b0);
    for (int i = 0; i < v.pre_len; i++) tick(1'b1, 2'b01, 1'b0);
    tick(1'b1, v.sfd, 1'b0);
    for (int i = 0; i < v.nbytes; i++) begin
      b = v.body[8*i +: 8];
      for (int p = 0; p < 4; p++) begin
        if (i == 0 && p == 0) body_start = cyc;
        if (p == 3 && in_data) begin
          exp_q.push_back(b[7:6]);
          exp_q.push_back(b[5:4]);
          exp_q.push_back(b[3:2]);
          exp_q.push_back(b[1:0]);
        end
        tick(1'b1, b[2*p +: 2], (i == v.rst_byte) && (p == 0));
      end
    end
    for (int e = 0; e < v.extra; e++) tick(1'b1, 2'(e + 1), 1'b0);
    fall_tick = cyc;
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    clear_frame_stats();
    drive_frame(v);
    idle(12);
    checkOutput($sformatf("v%0d_valid_count", idx), n_valid, v.exp_valid);
    checkOutput($sformatf("v%0d_burst_count", idx), bursts, (v.exp_valid > 0) ? 1 : 0);
    if (v.exp_valid > 0)
      checkOutput($sformatf("v%0d_first_latency", idx), first_v - body_start, 4);
    checkOutput($sformatf("v%0d_pre_err_pulses", idx), n_pre, v.exp_pre);
    checkOutput($sformatf("v%0d_align_err_pulses", idx), n_align, v.exp_align);
    if (v.exp_align > 0)
      checkOutput($sformatf("v%0d_align_err_timing", idx), align_tick - fall_tick, 1);
    checkOutput($sformatf("v%0d_scoreboard_drained", idx), exp_q.size(), 0);
  endtask

  // Main sequence: reset, table of frames, then multi-cycle corner cases
  initial begin
    crsdv = 1'b0;
    rxd   = 2'b00;
    rst   = 1'b1;

    //          lead pre  sfd    nb  body                    ext rstb valid pre aln
    vecs[0]  = '{0, 31, 2'b11, 4, 64'h00000000_BAB0EDFE, 0, -1, 16, 0, 0};
    vecs[1]  = '{0, 20, 2'b11, 4, 64'h00000000_BAB0EDFE, 0, -1,  0, 1, 0};
    vecs[2]  = '{0, 31, 2'b11, 2, 64'h00000000_00003412, 0, -1,  8, 0, 0};
    vecs[3]  = '{0, 31, 2'b11, 6, 64'h0000A5C3_7E810FF0, 2, -1, 24, 0, 1};
    vecs[4]  = '{0, 31, 2'b11, 6, 64'h00006655_44332211, 0,  3,  9, 0, 0};
    vecs[5]  = '{0, 31, 2'b11, 3, 64'h00000000_00A1B2C3, 0, -1, 12, 0, 0};
    vecs[6]  = '{0, 31, 2'b10, 2, 64'h00000000_00005A5A, 0, -1,  0, 1, 0};
    vecs[7]  = '{3, 70, 2'b11, 1, 64'h00000000_00000096, 0, -1,  4, 0, 0};
    vecs[8]  = '{0, 30, 2'b11, 2, 64'h00000000_00001234, 0, -1,  0, 1, 0};
    vecs[9]  = '{0,  0, 2'b11, 2, 64'h00000000_00001234, 0, -1,  0, 1, 0};
    vecs[10] = '{0, 32, 2'b00, 1, 64'h00000000_00000077, 0, -1,  0, 1, 0};
    good_a   = '{0, 31, 2'b11, 4, 64'h00000000_BAB0EDFE, 0, -1, 16, 0, 0};
    good_b   = '{0, 31, 2'b11, 4, 64'h00000000_0DF00DD0, 0, -1, 16, 0, 0};

    do_reset();
    idle(2);

    for (int i = 0; i < 11; i++) applyStimulus(vecs[i], i);

    // Carrier drops in the middle of the preamble
    clear_frame_stats();
    for (int i = 0; i < 10; i++) tick(1'b1, 2'b01, 1'b0);
    idle(6);
    checkOutput("pre_abort_pre_err_pulses", n_pre, 1);
    checkOutput("pre_abort_valid_count", n_valid, 0);

    // Two good frames separated by 48 idle cycles give two distinct bursts
    do_reset();
    idle(2);
    clear_frame_stats();
    drive_frame(good_a);
    checkOutput("two_frames_first_latency", first_v - body_start, 4);
    idle(48);
    drive_frame(good_b);
    idle(12);
    checkOutput("two_frames_valid_count", n_valid, 32);
    checkOutput("two_frames_burst_count", bursts, 2);
    checkOutput("two_frames_pre_err_pulses", n_pre, 0);
    checkOutput("two_frames_align_err_pulses", n_align, 0);
    checkOutput("two_frames_scoreboard_drained", exp_q.size(), 0);
`ifdef RMII_FRAME_RX_STATS_EN
    checkOutput("two_frames_frame_cnt", int'(frame_cnt), 2);
    checkOutput("two_frames_err_cnt", int'(err_cnt), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
